// File: rtl/hack_screen_fetch_pkg.sv
// Shared video constants and types for the Hack screen fetch path.
package hack_screen_fetch_pkg;

    localparam int unsigned H_OFFSET_DEFAULT = 64;
    localparam int unsigned V_OFFSET_DEFAULT = 112;

    localparam int unsigned SCREEN_W       = 512;
    localparam int unsigned SCREEN_H       = 256;
    localparam int unsigned WORDS_PER_LINE = 32;

    localparam int unsigned WORD_BITS  = 16;
    localparam int unsigned WORD_IDX_W = 5;
    localparam int unsigned BIT_IDX_W  = 4;
    localparam int unsigned ROW_W      = 8;
    localparam int unsigned ADDR_W     = ROW_W + WORD_IDX_W;

    localparam int unsigned LINE_BUF_DEPTH = 2 * WORDS_PER_LINE;

    typedef logic [WORD_BITS-1:0]  data_t;
    typedef logic [WORD_IDX_W-1:0] word_idx_t;
    typedef logic [BIT_IDX_W-1:0]  bit_idx_t;
    typedef logic [ROW_W-1:0]      row_t;

    localparam word_idx_t LAST_WORD = word_idx_t'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ABORT
    } fetch_state_t;

endpackage

// File: rtl/hack_line_buffer.sv
// Two-bank line buffer: 2 x 32 words of 16 bits, one write port and one
// registered read port. Contents are intentionally not reset.
module hack_line_buffer
    import hack_screen_fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  wr_bank,
    input  logic [WORD_IDX_W-1:0] wr_addr,
    input  logic [WORD_BITS-1:0]  wr_data,
    input  logic                  rd_bank,
    input  logic [WORD_IDX_W-1:0] rd_addr,
    output logic [WORD_BITS-1:0]  rd_data
);

    data_t mem [0:LINE_BUF_DEPTH-1];

    // Fill side: store one fetched word into the selected bank
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    // Display side: registered read of the selected bank
    always_ff @(posedge clk) begin
        rd_data <= mem[{rd_bank, rd_addr}];
    end

endmodule

// File: rtl/hack_screen_fetch.sv
// Hack screen fetch: streams one 512-px screen row per video line from word
// memory into a ping-pong line buffer and serialises the displayed row into
// a 1-bit pixel stream with sync signals aligned to it.
module hack_screen_fetch
    import hack_screen_fetch_pkg::*;
#(
    parameter int unsigned H_OFFSET = H_OFFSET_DEFAULT,
    parameter int unsigned V_OFFSET = V_OFFSET_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [9:0]           hpos,
    input  logic [9:0]           vpos,
    input  logic                 display_active,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_ack,
    input  logic [WORD_BITS-1:0] mem_data,
    output logic                 pixel,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic                 line_overrun
);

    localparam logic [10:0] H_LO       = 11'(H_OFFSET);
    localparam logic [10:0] H_HI       = 11'(H_OFFSET + SCREEN_W);
    localparam logic [10:0] V_LO       = 11'(V_OFFSET);
    localparam logic [10:0] V_HI       = 11'(V_OFFSET + SCREEN_H);
    localparam logic [10:0] EV_FIRST   = 11'(V_OFFSET - 1);
    localparam logic [10:0] EV_LAST    = 11'(V_OFFSET + SCREEN_H - 1);
    localparam logic [10:0] FETCH_LAST = 11'(V_OFFSET + SCREEN_H - 2);
    localparam row_t        ROW_BIAS   = row_t'(V_OFFSET - 1);

    logic [10:0]  hpos_x;
    logic [10:0]  vpos_x;
    logic         line_event;
    logic         starts_fetch;
    row_t         next_row;

    fetch_state_t state;
    word_idx_t    w;
    row_t         row;
    logic         bank;        // front (display) bank; the other one is filled
    logic         fill_bank;
    logic         restart;
    logic         wr_en;

    logic         in_window;
    logic [8:0]   x_pos;
    logic         s1_in;
    word_idx_t    s1_word;
    bit_idx_t     s1_bit;
    logic         s2_in;
    bit_idx_t     s2_bit;
    data_t        rd_data;

    logic [1:0]   hs_pipe;
    logic [1:0]   vs_pipe;

    assign hpos_x = {1'b0, hpos};
    assign vpos_x = {1'b0, vpos};

    assign line_event   = (hpos == '0) && (vpos_x >= EV_FIRST) && (vpos_x <= EV_LAST);
    assign starts_fetch = (vpos_x <= FETCH_LAST);
    // Row is only 8 bits wide, so the subtraction can be done modulo 256
    assign next_row     = vpos[7:0] - ROW_BIAS;

    // An ack coinciding with a line event or with reset is dropped
    assign wr_en = (state == FETCH) && mem_ack && !line_event && reset_n;

    // Fetch FSM, bank swap and sticky overrun flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            w            <= '0;
            row          <= '0;
            bank         <= 1'b0;
            fill_bank    <= 1'b0;
            restart      <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            line_overrun <= 1'b0;
        end else begin
            if (line_event) begin
                bank <= ~bank;
            end
            unique case (state)
                IDLE: begin
                    if (line_event && starts_fetch) begin
                        state     <= FETCH;
                        row       <= next_row;
                        fill_bank <= bank;  // old front becomes the new back
                        w         <= '0;
                        mem_req   <= 1'b1;
                        mem_addr  <= {next_row, word_idx_t'(0)};
                    end
                end
                FETCH: begin
                    if (line_event) begin
                        line_overrun <= 1'b1;
                        state        <= ABORT;
                        mem_req      <= 1'b0;
                        restart      <= starts_fetch;
                        if (starts_fetch) begin
                            row       <= next_row;
                            fill_bank <= bank;
                        end
                    end else if (mem_ack) begin
                        if (w == LAST_WORD) begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end else begin
                            w        <= w + 5'd1;
                            mem_addr <= {row, w + 5'd1};
                        end
                    end
                end
                ABORT: begin
                    if (line_event ? starts_fetch : restart) begin
                        state   <= FETCH;
                        w       <= '0;
                        mem_req <= 1'b1;
                        if (line_event) begin
                            row       <= next_row;
                            fill_bank <= bank;
                            mem_addr  <= {next_row, word_idx_t'(0)};
                        end else begin
                            mem_addr  <= {row, word_idx_t'(0)};
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign in_window = display_active
                    && (hpos_x >= H_LO) && (hpos_x < H_HI)
                    && (vpos_x >= V_LO) && (vpos_x < V_HI);

    // Window is 512 px wide, so the column offset fits modulo 512
    assign x_pos = hpos[8:0] - H_LO[8:0];

    // Pixel pipeline: stage 1 decodes position, stage 2 follows the buffer read
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_in   <= 1'b0;
            s1_word <= '0;
            s1_bit  <= '0;
            s2_in   <= 1'b0;
            s2_bit  <= '0;
        end else begin
            s1_in   <= in_window;
            s1_word <= x_pos[8:4];
            s1_bit  <= x_pos[3:0];
            s2_in   <= s1_in;
            s2_bit  <= s1_bit;
        end
    end

    // Hack stores 1 as black, bit 0 is the leftmost pixel of a word
    assign pixel = s2_in & ~rd_data[s2_bit];

    // Two-stage sync delay matching the pixel pipeline
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hs_pipe <= '1;
            vs_pipe <= '1;
        end else begin
            hs_pipe <= {hs_pipe[0], hsync_in};
            vs_pipe <= {vs_pipe[0], vsync_in};
        end
    end

    assign hsync_out = hs_pipe[1];
    assign vsync_out = vs_pipe[1];

    hack_line_buffer u_line_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_bank (fill_bank),
        .wr_addr (w),
        .wr_data (mem_data),
        .rd_bank (bank),
        .rd_addr (s1_word),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_hack_screen_fetch.sv
// Self-checking bench for hack_screen_fetch: behavioural model compared every
// cycle plus hand-computed literal expectations on directed sequences.
module tb_hack_screen_fetch;

    localparam int H_OFF = 64;
    localparam int V_OFF = 112;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        display_active;
    logic        hsync_in;
    logic        vsync_in;
    logic        mem_req;
    logic [12:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        pixel;
    logic        hsync_out;
    logic        vsync_out;
    logic        line_overrun;

    logic [15:0] mem_tb [0:8191];
    assign mem_data = mem_tb[mem_addr];

    always #5 clk = ~clk;

    hack_screen_fetch #(.H_OFFSET(H_OFF), .V_OFFSET(V_OFF)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .hpos           (hpos),
        .vpos           (vpos),
        .display_active (display_active),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_data       (mem_data),
        .pixel          (pixel),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .line_overrun   (line_overrun)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit armed = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_line [0:1][0:31];
    int m_mode;     // 0 idle, 1 fetching, 2 one-cycle abort gap
    int m_front, m_fill, m_row, m_w, m_addr;
    bit m_restart, m_req, m_ovr, m_pix;
    bit p_in;
    int p_word, p_bit;
    bit m_hs, m_hs1, m_vs, m_vs1;

    always @(posedge clk) begin
        int h, v, nr;
        bit ev, st;
        h = int'(hpos);
        v = int'(vpos);
        if (!reset_n) begin
            m_mode = 0; m_front = 0; m_fill = 0; m_row = 0; m_w = 0; m_addr = 0;
            m_restart = 0; m_req = 0; m_ovr = 0; m_pix = 0; p_in = 0;
            m_hs = 1; m_hs1 = 1; m_vs = 1; m_vs1 = 1;
        end else begin
            m_pix = p_in && !m_line[m_front][p_word][p_bit];
            p_in = display_active && h >= H_OFF && h < H_OFF + 512 && v >= V_OFF && v < V_OFF + 256;
            if (p_in) begin
                p_word = (h - H_OFF) / 16;
                p_bit  = (h - H_OFF) % 16;
            end
            m_hs = m_hs1; m_hs1 = hsync_in;
            m_vs = m_vs1; m_vs1 = vsync_in;

            ev = (h == 0) && (v >= V_OFF - 1) && (v <= V_OFF + 255);
            st = (v <= V_OFF + 254);
            nr = v - V_OFF + 1;
            case (m_mode)
                0: if (ev && st) begin m_mode = 1; m_row = nr; m_w = 0; end
                1: begin
                    if (ev) begin
                        m_ovr = 1; m_mode = 2; m_restart = st;
                        if (st) m_row = nr;
                    end else if (mem_ack) begin
                        m_line[m_fill][m_w] = mem_tb[m_row * 32 + m_w];
                        if (m_w == 31) m_mode = 0;
                        else m_w++;
                    end
                end
                default: begin m_mode = m_restart ? 1 : 0; m_w = 0; end
            endcase
            if (ev) begin
                m_front = 1 - m_front;
                if (st) m_fill = 1 - m_front;
            end
            m_req  = (m_mode == 1);
            m_addr = m_row * 32 + m_w;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (armed) begin
            chk("mem_req", mem_req, m_req);
            if (m_req) chk("mem_addr", mem_addr, m_addr);
            chk("pixel", pixel, m_pix);
            chk("hsync_out", hsync_out, m_hs);
            chk("vsync_out", vsync_out, m_vs);
            chk("line_overrun", line_overrun, m_ovr);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int h, input int v);
        hpos = 10'(h);
        vpos = 10'(v);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8192; i++) mem_tb[i] = 16'h0000;
        mem_tb[0]        = 16'h0001;
        mem_tb[254 * 32] = 16'hFFFF;
        reset_n = 1'b0; hpos = 10'd1; vpos = 10'd0; display_active = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1; mem_ack = 1'b1;

        // Reset state
        tick();
        armed = 1'b1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_pixel", pixel, 0);
        chk("rst_overrun", line_overrun, 0);
        reset_n = 1'b1;
        step(1, 0);

        // Row 0 fetch with ack tied high
        step(0, 111);
        chk("f0_req", mem_req, 1);
        chk("f0_addr", mem_addr, 0);
        for (int k = 1; k <= 31; k++) begin
            step(1, 111);
            chk("f0_addr_seq", mem_addr, k);
        end
        step(1, 111);
        chk("f0_req_done", mem_req, 0);

        // Display row 0: word0 = 0x0001
        step(0, 112);
        display_active = 1'b1;
        for (int h = 1; h <= 600; h++) begin
            vsync_in = (h >= 200 && h < 204) ? 1'b0 : 1'b1;
            step(h, 112);
            if (h - 1 == 63 || h - 1 == 64 || h - 1 == 576)
                chk("pix_edge", pixel, 0);
            if (h - 1 == 65 || h - 1 == 79 || h - 1 == 320 || h - 1 == 575)
                chk("pix_white", pixel, 1);
        end
        display_active = 1'b0;

        // 96-cycle hsync pulse delayed by 2
        for (int i = 0; i < 100; i++) begin
            hsync_in = (i < 96) ? 1'b0 : 1'b1;
            step(1, 112);
            chk("hsync_delay", hsync_out, (i >= 1 && i <= 96) ? 0 : 1);
        end
        hsync_in = 1'b1;

        // Slow memory: overrun, abort gap, restart at row 1
        mem_ack = 1'b0;
        step(0, 111);
        for (int c = 1; c <= 100; c++) begin
            mem_ack = (c % 30 == 0);
            step(1, 111);
        end
        mem_ack = 1'b0;
        step(0, 112);
        chk("ovr_flag", line_overrun, 1);
        chk("ovr_gap_req", mem_req, 0);
        step(1, 112);
        chk("ovr_restart_req", mem_req, 1);
        chk("ovr_restart_addr", mem_addr, 32);
        mem_ack = 1'b1;
        for (int c = 0; c < 40; c++) step(1, 112);
        chk("ovr_sticky", line_overrun, 1);

        // Reset mid-fetch at w=10
        step(0, 111);
        for (int c = 0; c < 10; c++) step(1, 111);
        chk("mid_addr10", mem_addr, 10);
        reset_n = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        step(1, 111);
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_pixel", pixel, 0);
        chk("mid_rst_hs", hsync_out, 1);
        chk("mid_rst_vs", vsync_out, 1);
        chk("mid_rst_ovr", line_overrun, 0);
        step(1, 111);
        chk("mid_rst_hs2", hsync_out, 1);
        reset_n = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        step(1, 111);
        step(0, 111);
        chk("post_rst_req", mem_req, 1);
        chk("post_rst_addr", mem_addr, 0);
        step(1, 111);
        chk("post_rst_addr1", mem_addr, 1);
        for (int c = 0; c < 40; c++) step(1, 111);

        // Last lines: 367 toggles without fetch, 368 is not a line event
        step(0, 365);
        for (int c = 0; c < 40; c++) step(1, 365);
        step(0, 366);
        for (int c = 0; c < 40; c++) step(1, 366);
        step(0, 367);
        chk("l367_no_req", mem_req, 0);
        for (int c = 0; c < 3; c++) begin
            step(1, 367);
            chk("l367_no_req_hold", mem_req, 0);
        end
        display_active = 1'b1;
        for (int h = 60; h <= 82; h++) begin
            step(h, 367);
            if (h - 1 == 64) chk("l367_front_row255", pixel, 1);
        end
        display_active = 1'b0;
        step(0, 368);
        chk("l368_no_req", mem_req, 0);
        step(1, 368);
        display_active = 1'b1;
        for (int h = 60; h <= 82; h++) begin
            step(h, 367);
            if (h - 1 == 64) chk("l368_no_toggle", pixel, 1);
        end
        display_active = 1'b0;
        step(1, 368);
        step(1, 368);

        armed = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hack_screen_fetch.md
HACK_SCREEN_FETCH -- requirements
Module: hack_screen_fetch

Interface
REQ-001 SHALL have parameter H_OFFSET, default 64, meaning first active hpos of the 512-px Hack window.
REQ-002 SHALL have parameter V_OFFSET, default 112, meaning first active vpos of the 256-line Hack window.
REQ-003 SHALL have port clk  input  1  sole clock; the block uses one clock, and all logic is on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have ports hpos, vpos  input  10 each  current pixel position from the video generator.
REQ-006 SHALL have ports display_active, hsync_in, vsync_in  input  1 each  timing from the video generator.
REQ-007 SHALL have port mem_req  output  1  word read request.
REQ-008 SHALL have port mem_addr  output  13  screen-relative word address.
REQ-009 SHALL have port mem_ack  input  1  read-data-valid strobe.
REQ-010 SHALL have port mem_data  input  16  read data, valid when mem_ack=1.
REQ-011 SHALL have port pixel  output  1  1=white, 0=black.
REQ-012 SHALL have ports hsync_out, vsync_out  output  1 each  sync inputs delayed to align with pixel.
REQ-013 SHALL have port line_overrun  output  1  sticky flag: a row fetch failed to complete in time.

Function
REQ-014 SHALL hold two 32x16 line banks, one front (display) and one back (fill), selected by one bank bit.
REQ-015 SHALL define a line event as hpos==0 with vpos in [V_OFFSET-1, V_OFFSET+255].
REQ-016 SHALL toggle the bank bit on every line event.
REQ-017 SHALL, on a line event with vpos<=V_OFFSET+254, start fetching row r=vpos-V_OFFSET+1 into the new back bank.
REQ-018 SHALL use fetch FSM states IDLE, FETCH and ABORT.
REQ-019 SHALL make the IDLE->FETCH transition on a line event that starts a fetch; word counter w=0.
REQ-020 SHALL, in FETCH, drive mem_req=1 and mem_addr=r*32+w, with the address stable until a cycle with mem_ack=1.
REQ-021 SHALL, on mem_ack=1 in FETCH, write mem_data to back[w] and increment w; mem_req stays high with the next address (back-to-back allowed).
REQ-022 SHALL, when the ack for w=31 arrives, transition FETCH->IDLE and set mem_req=0 from the next cycle.
REQ-023 SHALL, if a line event occurs while in FETCH, set line_overrun=1 and go FETCH->ABORT (mem_req=0 for exactly one cycle), then ABORT->FETCH with w=0 for the new row.
REQ-024 SHALL ignore mem_ack while in IDLE or ABORT.
REQ-025 SHALL form pixel over a 2-cycle pipeline: stage 1 registers the in-window flag, the column word (x>>4) and the bit index x[3:0], where x=hpos-H_OFFSET; stage 2 reads front[word][bit].
REQ-026 SHALL define in-window as display_active && H_OFFSET<=hpos<H_OFFSET+512 && V_OFFSET<=vpos<V_OFFSET+256.
REQ-027 SHALL drive pixel = ~front[word][bit] in-window (Hack 1=black; bit 0 = leftmost), else 0.
REQ-028 SHALL delay hsync_out and vsync_out by exactly 2 cycles from hsync_in and vsync_in.
REQ-029 SHALL keep line_overrun set until reset.

Reset
REQ-030 SHALL, while reset_n=0 at a clock edge, force: FSM=IDLE, w=0, bank=0, mem_req=0, mem_addr=0, pixel=0, hsync_out=1, vsync_out=1, sync pipes=1, line_overrun=0.
REQ-031 SHALL leave line bank contents unreset.
REQ-032 SHALL, on reset asserted mid-fetch, drop mem_req on the next edge and discard any ack in that cycle.

Structure
REQ-033 SHALL place H_OFFSET/V_OFFSET defaults, SCREEN_W=512, SCREEN_H=256 and WORDS_PER_LINE=32 in the shared video constants package.
REQ-034 SHALL instantiate exactly one sub-module, hack_line_buffer (2 banks x 32 x 16, 1 write port, 1 registered read port).

Verification
REQ-035 SHALL cover, with mem_ack tied 1: vpos=111,hpos=0 -> mem_req=1 next cycle, mem_addr 0..31 on consecutive cycles, then mem_req=0.
REQ-036 SHALL cover: row0 word0=0x0001, others 0x0000, vpos=112 -> pixel=0 for hpos=64 and 1 for hpos=65..575, seen 2 cycles later; 0 at hpos 63 and 576.
REQ-037 SHALL cover: mem_ack once per 30 cycles -> line_overrun=1 after the next line event, mem_req low one cycle, fetch restarts at r*32.
REQ-038 SHALL cover: reset_n=0 at w=10 -> mem_req=0 next edge, all REQ-030 values hold, and the next fetch starts at w=0.
REQ-039 SHALL cover: vpos=367,hpos=0 -> bank toggles with no mem_req; vpos=368,hpos=0 -> no toggle.
REQ-040 SHALL cover: hsync_in pulse of 96 cycles -> identical pulse on hsync_out delayed exactly 2 cycles.
